// File: rtl/uart_cmd_host.sv
// Host-side UART command initiator: serialises one command frame into the TX byte FIFO,
// then gathers the reply bytes from the RX path and reports them with a timeout flag.
module uart_cmd_host #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int TMO_WIDTH  = 16,
    parameter int TMO_CYCLES = 1000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_vld_i,
    output logic                    cmd_rdy_o,
    input  logic [1:0]              cmd_type_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_opa_i,
    input  logic [DATA_WIDTH-1:0]   cmd_opb_i,
    input  logic [3:0]              cmd_fun_i,
    input  logic                    tx_full_i,
    output logic                    tx_wr_inc_o,
    output logic [DATA_WIDTH-1:0]   tx_wr_data_o,
    input  logic [DATA_WIDTH-1:0]   rx_data_i,
    input  logic                    rx_vld_i,
    output logic [2*DATA_WIDTH-1:0] rsp_data_o,
    output logic                    rsp_vld_o,
    output logic                    rsp_timeout_o
);

    localparam logic [1:0] CMD_RF_WR  = 2'd0;
    localparam logic [1:0] CMD_RF_RD  = 2'd1;
    localparam logic [1:0] CMD_ALU_W  = 2'd2;
    localparam logic [1:0] CMD_ALU_NO = 2'd3;

    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TMO_CYCLES - 1);
    localparam logic [TMO_WIDTH-1:0] TMO_ONE  = {{(TMO_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TMO_WIDTH-1:0] TMO_ZERO = {TMO_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    function automatic logic [1:0] tx_last_idx(input logic [1:0] typ);
        logic [1:0] last;
        case (typ)
            CMD_RF_WR:  last = 2'd2;
            CMD_RF_RD:  last = 2'd1;
            CMD_ALU_W:  last = 2'd3;
            CMD_ALU_NO: last = 2'd1;
            default:    last = 2'd1;
        endcase
        return last;
    endfunction

    function automatic logic [1:0] rsp_len(input logic [1:0] typ);
        logic [1:0] len;
        case (typ)
            CMD_RF_WR:  len = 2'd0;
            CMD_RF_RD:  len = 2'd1;
            CMD_ALU_W:  len = 2'd2;
            CMD_ALU_NO: len = 2'd2;
            default:    len = 2'd0;
        endcase
        return len;
    endfunction

    // Byte idx of the frame; header byte first, ADDR/FUN fields zero-extended.
    function automatic logic [DATA_WIDTH-1:0] frame_byte(
        input logic [1:0]            typ,
        input logic [1:0]            idx,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] opa,
        input logic [DATA_WIDTH-1:0] opb,
        input logic [3:0]            fun
    );
        logic [DATA_WIDTH-1:0] b;
        b = {DATA_WIDTH{1'b0}};
        case (typ)
            CMD_RF_WR: begin
                case (idx)
                    2'd0:    b = DATA_WIDTH'(8'hAA);
                    2'd1:    b = DATA_WIDTH'(addr);
                    2'd2:    b = opa;
                    default: b = {DATA_WIDTH{1'b0}};
                endcase
            end
            CMD_RF_RD: begin
                case (idx)
                    2'd0:    b = DATA_WIDTH'(8'hBB);
                    2'd1:    b = DATA_WIDTH'(addr);
                    default: b = {DATA_WIDTH{1'b0}};
                endcase
            end
            CMD_ALU_W: begin
                case (idx)
                    2'd0:    b = DATA_WIDTH'(8'hCC);
                    2'd1:    b = opa;
                    2'd2:    b = opb;
                    2'd3:    b = DATA_WIDTH'(fun);
                    default: b = {DATA_WIDTH{1'b0}};
                endcase
            end
            CMD_ALU_NO: begin
                case (idx)
                    2'd0:    b = DATA_WIDTH'(8'hDD);
                    2'd1:    b = DATA_WIDTH'(fun);
                    default: b = {DATA_WIDTH{1'b0}};
                endcase
            end
            default: b = {DATA_WIDTH{1'b0}};
        endcase
        return b;
    endfunction

    state_e                  state_q,       state_d;
    logic [1:0]              typ_q,         typ_d;
    logic [ADDR_WIDTH-1:0]   addr_q,        addr_d;
    logic [DATA_WIDTH-1:0]   opa_q,         opa_d;
    logic [DATA_WIDTH-1:0]   opb_q,         opb_d;
    logic [3:0]              fun_q,         fun_d;
    logic [1:0]              idx_q,         idx_d;
    logic [1:0]              rx_cnt_q,      rx_cnt_d;
    logic [TMO_WIDTH-1:0]    tmo_cnt_q,     tmo_cnt_d;
    logic                    tmo_flag_q,    tmo_flag_d;
    logic [2*DATA_WIDTH-1:0] rsp_data_q,    rsp_data_d;
    logic                    rsp_vld_q,     rsp_vld_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    logic                    tx_wr_inc_s;
    logic [DATA_WIDTH-1:0]   tx_wr_data_s;

    // FIFO write port: offer the current frame byte whenever the FIFO has room.
    always_comb begin
        if (state_q == S_SEND) begin
            tx_wr_inc_s  = !tx_full_i;
            tx_wr_data_s = frame_byte(typ_q, idx_q, addr_q, opa_q, opb_q, fun_q);
        end else begin
            tx_wr_inc_s  = 1'b0;
            tx_wr_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Next-state logic for the command FSM and its datapath registers.
    always_comb begin
        state_d       = state_q;
        typ_d         = typ_q;
        addr_d        = addr_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        fun_d         = fun_q;
        idx_d         = idx_q;
        rx_cnt_d      = rx_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        tmo_flag_d    = tmo_flag_q;
        rsp_data_d    = rsp_data_q;
        rsp_vld_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_vld_i) begin
                    typ_d      = cmd_type_i;
                    addr_d     = cmd_addr_i;
                    opa_d      = cmd_opa_i;
                    opb_d      = cmd_opb_i;
                    fun_d      = cmd_fun_i;
                    idx_d      = 2'd0;
                    rx_cnt_d   = 2'd0;
                    tmo_cnt_d  = TMO_ZERO;
                    tmo_flag_d = 1'b0;
                    rsp_data_d = {(2*DATA_WIDTH){1'b0}};
                    state_d    = S_SEND;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                if (tx_wr_inc_s) begin
                    if (idx_q == tx_last_idx(typ_q)) begin
                        idx_d   = 2'd0;
                        state_d = (rsp_len(typ_q) == 2'd0) ? S_DONE : S_WAIT_RSP;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            S_WAIT_RSP: begin
                // A byte arriving on the timeout cycle still counts and restarts the wait.
                if (rx_vld_i) begin
                    if (rx_cnt_q == 2'd0) begin
                        rsp_data_d[DATA_WIDTH-1:0] = rx_data_i;
                    end else begin
                        rsp_data_d[2*DATA_WIDTH-1:DATA_WIDTH] = rx_data_i;
                    end
                    rx_cnt_d  = rx_cnt_q + 2'd1;
                    tmo_cnt_d = TMO_ZERO;
                    if ((rx_cnt_q + 2'd1) == rsp_len(typ_q)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT_RSP;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_flag_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                end
            end
            S_DONE: begin
                rsp_vld_d     = 1'b1;
                rsp_timeout_d = tmo_flag_q;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            typ_q         <= 2'd0;
            addr_q        <= {ADDR_WIDTH{1'b0}};
            opa_q         <= {DATA_WIDTH{1'b0}};
            opb_q         <= {DATA_WIDTH{1'b0}};
            fun_q         <= 4'd0;
            idx_q         <= 2'd0;
            rx_cnt_q      <= 2'd0;
            tmo_cnt_q     <= TMO_ZERO;
            tmo_flag_q    <= 1'b0;
            rsp_data_q    <= {(2*DATA_WIDTH){1'b0}};
            rsp_vld_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            typ_q         <= typ_d;
            addr_q        <= addr_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            fun_q         <= fun_d;
            idx_q         <= idx_d;
            rx_cnt_q      <= rx_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            tmo_flag_q    <= tmo_flag_d;
            rsp_data_q    <= rsp_data_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_rdy_o     = (state_q == S_IDLE);
    assign tx_wr_inc_o   = tx_wr_inc_s;
    assign tx_wr_data_o  = tx_wr_data_s;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_vld_o     = rsp_vld_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed, table-driven bench for uart_cmd_host with hand-written sequences for
// timeout, RX-on-timeout-cycle, idle RX pulses and mid-frame reset.
module tb_uart_cmd_host;

    localparam int TMO = 20;

    logic        clk;
    logic        rst_n;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_opa;
    logic [7:0]  cmd_opb;
    logic [3:0]  cmd_fun;
    logic        tx_full;
    logic        tx_wr_inc;
    logic [7:0]  tx_wr_data;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [15:0] rsp_data;
    logic        rsp_vld;
    logic        rsp_timeout;

    int n_chk  = 0;
    int n_fail = 0;

    uart_cmd_host #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .TMO_WIDTH (16),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_vld_i    (cmd_vld),
        .cmd_rdy_o    (cmd_rdy),
        .cmd_type_i   (cmd_type),
        .cmd_addr_i   (cmd_addr),
        .cmd_opa_i    (cmd_opa),
        .cmd_opb_i    (cmd_opb),
        .cmd_fun_i    (cmd_fun),
        .tx_full_i    (tx_full),
        .tx_wr_inc_o  (tx_wr_inc),
        .tx_wr_data_o (tx_wr_data),
        .rx_data_i    (rx_data),
        .rx_vld_i     (rx_vld),
        .rsp_data_o   (rsp_data),
        .rsp_vld_o    (rsp_vld),
        .rsp_timeout_o(rsp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tx holds frame bytes with byte 0 in [7:0]; rx holds reply bytes in arrival order from [7:0].
    typedef struct {
        logic [1:0]  typ;
        logic [3:0]  addr;
        logic [7:0]  opa;
        logic [7:0]  opb;
        logic [3:0]  fun;
        int          n;
        logic [31:0] tx;
        int          st_from;
        int          st_len;
        int          nrsp;
        int          gap;
        logic [15:0] rx;
        logic [15:0] exp;
    } vec_t;

    localparam int NV = 7;
    vec_t v [NV];

    function automatic vec_t mk(input logic [1:0] typ, input logic [3:0] addr,
                                input logic [7:0] opa, input logic [7:0] opb,
                                input logic [3:0] fun, input int n, input logic [31:0] tx,
                                input int st_from, input int st_len, input int nrsp,
                                input int gap, input logic [15:0] rx, input logic [15:0] exp);
        vec_t r;
        r.typ = typ; r.addr = addr; r.opa = opa; r.opb = opb; r.fun = fun;
        r.n = n; r.tx = tx; r.st_from = st_from; r.st_len = st_len;
        r.nrsp = nrsp; r.gap = gap; r.rx = rx; r.exp = exp;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] typ, input logic [3:0] addr, input logic [7:0] opa,
                            input logic [7:0] opb, input logic [3:0] fun);
        cmd_type = typ; cmd_addr = addr; cmd_opa = opa; cmd_opb = opb; cmd_fun = fun;
        cmd_vld  = 1'b1;
        @(negedge clk);
        chk("cmd_rdy_idle", {31'd0, cmd_rdy}, 32'd1);
        next_cycle();
        cmd_vld  = 1'b0;
        cmd_type = ~typ; cmd_addr = ~addr; cmd_opa = ~opa; cmd_opb = ~opb; cmd_fun = ~fun;
    endtask

    // Collects n frame bytes, holding TX_FULL on cycles [st_from, st_from+st_len).
    task automatic send_frame(input string tag, input logic [31:0] eb, input int n,
                              input int st_from, input int st_len);
        int got;
        int c;
        got = 0;
        c   = 1;
        while (got < n && c < 40) begin
            tx_full = (c >= st_from) && (c < st_from + st_len);
            @(negedge clk);
            chk({tag, "_busy"}, {31'd0, cmd_rdy}, 32'd0);
            if (tx_full) begin
                chk({tag, "_stall"}, {31'd0, tx_wr_inc}, 32'd0);
            end else begin
                chk({tag, "_wr"}, {31'd0, tx_wr_inc}, 32'd1);
                if (tx_wr_inc) begin
                    chk({tag, "_byte"}, {24'd0, tx_wr_data}, {24'd0, eb[8*got +: 8]});
                    got++;
                end
            end
            next_cycle();
            c++;
        end
        tx_full = 1'b0;
        chk({tag, "_nbytes"}, got, n);
    endtask

    task automatic idle_chk(input string tag, input int n);
        repeat (n) begin
            @(negedge clk);
            chk({tag, "_no_tx"}, {31'd0, tx_wr_inc}, 32'd0);
            chk({tag, "_no_vld"}, {31'd0, rsp_vld}, 32'd0);
            next_cycle();
        end
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        next_cycle();
        rx_vld  = 1'b0;
        rx_data = 8'h00;
    endtask

    // Called on the cycle after the final event: one DONE cycle, then the RSP_VLD pulse.
    task automatic expect_rsp(input string tag, input logic [15:0] exp_data, input logic exp_tmo);
        @(negedge clk);
        chk({tag, "_done_vld"}, {31'd0, rsp_vld}, 32'd0);
        chk({tag, "_done_tx"}, {31'd0, tx_wr_inc}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk({tag, "_rsp_vld"}, {31'd0, rsp_vld}, 32'd1);
        chk({tag, "_rsp_data"}, {16'd0, rsp_data}, {16'd0, exp_data});
        chk({tag, "_rsp_tmo"}, {31'd0, rsp_timeout}, {31'd0, exp_tmo});
        chk({tag, "_rdy_back"}, {31'd0, cmd_rdy}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk({tag, "_vld_pulse"}, {31'd0, rsp_vld}, 32'd0);
        chk({tag, "_hold"}, {16'd0, rsp_data}, {16'd0, exp_data});
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        v[0] = mk(2'd0, 4'h5, 8'h3C, 8'h77, 4'hA, 3, 32'h003C05AA, 0, 0, 0, 0,  16'h0000, 16'h0000);
        v[1] = mk(2'd1, 4'h2, 8'h99, 8'h66, 4'h5, 2, 32'h000002BB, 0, 0, 1, 10, 16'h007E, 16'h007E);
        v[2] = mk(2'd2, 4'hC, 8'h0A, 8'h14, 4'h0, 4, 32'h00140ACC, 2, 5, 2, 3,  16'h001E, 16'h001E);
        v[3] = mk(2'd3, 4'h1, 8'h55, 8'hAA, 4'hF, 2, 32'h00000FDD, 0, 0, 2, 1,  16'h1234, 16'h1234);
        v[4] = mk(2'd1, 4'hF, 8'h00, 8'h00, 4'h3, 2, 32'h00000FBB, 0, 0, 1, 1,  16'h00FF, 16'h00FF);
        v[5] = mk(2'd0, 4'h0, 8'hFF, 8'h12, 4'h6, 3, 32'h00FF00AA, 1, 3, 0, 0,  16'h0000, 16'h0000);
        v[6] = mk(2'd2, 4'h7, 8'hFF, 8'h80, 4'h9, 4, 32'h0980FFCC, 4, 2, 2, 5,  16'hBEEF, 16'hBEEF);

        rst_n = 1'b1; cmd_vld = 1'b0; cmd_type = 2'd0; cmd_addr = 4'h0; cmd_opa = 8'h00;
        cmd_opb = 8'h00; cmd_fun = 4'h0; tx_full = 1'b0; rx_data = 8'h00; rx_vld = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("rst_tx_inc", {31'd0, tx_wr_inc}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_wr_data}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        chk("rst_rsp_tmo", {31'd0, rsp_timeout}, 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            send_cmd(v[i].typ, v[i].addr, v[i].opa, v[i].opb, v[i].fun);
            send_frame(nm, v[i].tx, v[i].n, v[i].st_from, v[i].st_len);
            if (v[i].nrsp > 0) begin
                idle_chk(nm, v[i].gap - 1);
                pulse_rx(v[i].rx[7:0]);
                if (v[i].nrsp > 1) begin
                    idle_chk(nm, 3);
                    pulse_rx(v[i].rx[15:8]);
                end
            end
            expect_rsp(nm, v[i].exp, 1'b0);
        end

        // One reply byte then silence: timeout fires on the 20th silent cycle.
        send_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h2);
        send_frame("t4", 32'h000002DD, 2, 0, 0);
        idle_chk("t4", 2);
        pulse_rx(8'h05);
        idle_chk("t4_wait", TMO);
        expect_rsp("t4", 16'h0005, 1'b1);

        // No reply at all: timeout with a cleared RSP_DATA.
        send_cmd(2'd1, 4'h9, 8'h00, 8'h00, 4'h0);
        send_frame("tnr", 32'h000009BB, 2, 0, 0);
        idle_chk("tnr_wait", TMO);
        expect_rsp("tnr", 16'h0000, 1'b1);

        // Second byte lands exactly on the timeout cycle.
        send_cmd(2'd3, 4'h0, 8'h00, 8'h00, 4'h7);
        send_frame("t6", 32'h000007DD, 2, 0, 0);
        pulse_rx(8'hA5);
        idle_chk("t6_wait", TMO - 1);
        pulse_rx(8'h5A);
        expect_rsp("t6", 16'h5AA5, 1'b0);
        pulse_rx(8'h77);
        idle_chk("t6_idle", 1);
        pulse_rx(8'h88);
        @(negedge clk);
        chk("t6_idle_rsp_data", {16'd0, rsp_data}, 32'h00005AA5);
        chk("t6_idle_rdy", {31'd0, cmd_rdy}, 32'd1);
        next_cycle();

        // Reset after two bytes of an ALU_W_OP frame.
        send_cmd(2'd2, 4'h0, 8'h11, 8'h22, 4'h3);
        send_frame("t5", 32'h032211CC, 2, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tx_inc", {31'd0, tx_wr_inc}, 32'd0);
        chk("t5_rst_tx_data", {24'd0, tx_wr_data}, 32'd0);
        chk("t5_rst_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("t5_rst_vld", {31'd0, rsp_vld}, 32'd0);
        chk("t5_rst_data", {16'd0, rsp_data}, 32'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        idle_chk("t5_post", 8);
        @(negedge clk);
        chk("t5_post_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("t5_post_data", {16'd0, rsp_data}, 32'd0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
